// File: rtl/lcd_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | lcd_pkg : shared constants, state encoding and helper functions for the  |
// |           Spartan-3E character LCD command sequencer.                    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package lcd_pkg;

  // HD44780 instructions as {RS, RW, data[7:0]}
  localparam logic [9:0] FUNC_SET   = 10'h028;
  localparam logic [9:0] ENTRY_MODE = 10'h006;
  localparam logic [9:0] DISP_ON    = 10'h00C;
  localparam logic [9:0] CLEAR      = 10'h001;
  localparam logic [9:0] DDRAM_L1   = 10'h080;
  localparam logic [9:0] DDRAM_L2   = 10'h0C0;

  localparam logic [2:0] CMD_IDX_CLEAR = 3'd3;
  localparam logic [2:0] CMD_IDX_L1    = 3'd4;
  localparam logic [2:0] CMD_IDX_L2    = 3'd5;

  // Default timing at 50 MHz
  localparam int T_POWERON_DEF = 750000;
  localparam int T_4100US_DEF  = 205000;
  localparam int T_100US_DEF   = 5000;
  localparam int T_40US_DEF    = 2000;
  localparam int T_CLEAR_DEF   = 82000;
  localparam int NUM_COLS_DEF  = 16;
  localparam int WAIT_W_DEF    = 20;

  // LCD_E framing, shared with the instruction FSM
  localparam int E_SETUP_CYC = 2;
  localparam int E_HIGH_CYC  = 12;
  localparam int E_HOLD_CYC  = 1;
  localparam int E_TOTAL_CYC = E_SETUP_CYC + E_HIGH_CYC + E_HOLD_CYC;

  localparam logic [3:0] INIT_NIB_A = 4'h3;
  localparam logic [3:0] INIT_NIB_B = 4'h2;

  typedef enum logic [3:0] {
    PWR_WAIT   = 4'd0,
    INIT_NIB   = 4'd1,
    INIT_WAIT  = 4'd2,
    CMD_ISSUE  = 4'd3,
    CMD_WAIT   = 4'd4,
    CLR_WAIT   = 4'd5,
    CHAR_FETCH = 4'd6,
    CHAR_ISSUE = 4'd7,
    CHAR_WAIT  = 4'd8,
    DONE       = 4'd9
  } seq_state_e;

  function automatic logic [3:0] init_nibble(input logic [1:0] idx);
    return (idx == 2'd3) ? INIT_NIB_B : INIT_NIB_A;
  endfunction

  function automatic logic [9:0] cmd_db(input logic [2:0] idx);
    logic [9:0] r;
    case (idx)
      3'd0:    r = FUNC_SET;
      3'd1:    r = ENTRY_MODE;
      3'd2:    r = DISP_ON;
      3'd3:    r = CLEAR;
      3'd4:    r = DDRAM_L1;
      default: r = DDRAM_L2;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_wait_timer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | lcd_wait_timer : loadable down-counter, expired while the count is zero. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module lcd_wait_timer #(
  parameter int                WAIT_W    = 20,
  parameter logic [WAIT_W-1:0] RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [WAIT_W-1:0] load_val,
  output logic              expired
);

  logic [WAIT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d = count_q - WAIT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= RESET_VAL;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/lcd_command_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | lcd_command_sequencer : HD44780 power-on init, configuration and 2x16    |
// |   message issue. Optional macro LCD_SEQ_REFRESH_EN rewrites the message  |
// |   periodically from DONE.                                                |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module lcd_command_sequencer
  import lcd_pkg::*;
#(
  parameter int T_POWERON = T_POWERON_DEF,
  parameter int T_4100US  = T_4100US_DEF,
  parameter int T_100US   = T_100US_DEF,
  parameter int T_40US    = T_40US_DEF,
  parameter int T_CLEAR   = T_CLEAR_DEF,
  parameter int NUM_COLS  = NUM_COLS_DEF,
  parameter int WAIT_W    = WAIT_W_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        done,
  input  logic [7:0]  char_data,
  output logic        next_instruction,
  output logic [9:0]  db,
  output logic [11:0] clk_cnt,
  output logic [4:0]  char_addr,
  output logic        init_active,
  output logic [3:0]  init_sf_d,
  output logic        init_lcd_e,
  output logic        seq_done
);

  localparam logic [4:0] LAST_L1  = 5'(NUM_COLS - 1);
  localparam logic [4:0] START_L2 = 5'(NUM_COLS);
  localparam logic [4:0] LAST_L2  = 5'(2 * NUM_COLS - 1);

  seq_state_e  state_q, state_d;
  logic [1:0]  nib_idx_q, nib_idx_d;
  logic [3:0]  e_cnt_q, e_cnt_d;
  logic [2:0]  cmd_idx_q, cmd_idx_d;
  logic        fetch_ph_q, fetch_ph_d;
  logic        next_instr_q, next_instr_d;
  logic [9:0]  db_q, db_d;
  logic [11:0] clk_cnt_q, clk_cnt_d;
  logic [4:0]  char_addr_q, char_addr_d;
  logic        init_active_q, init_active_d;
  logic [3:0]  init_sf_d_q, init_sf_d_d;
  logic        init_lcd_e_q, init_lcd_e_d;
  logic        seq_done_q, seq_done_d;

  logic              tmr_load;
  logic [WAIT_W-1:0] tmr_val;
  logic              tmr_expired;

  lcd_wait_timer #(
    .WAIT_W    (WAIT_W),
    .RESET_VAL (WAIT_W'(T_POWERON))
  ) u_wait_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expired  (tmr_expired)
  );

  function automatic logic [WAIT_W-1:0] init_wait_len(input logic [1:0] idx);
    logic [WAIT_W-1:0] r;
    case (idx)
      2'd0:    r = WAIT_W'(T_4100US);
      2'd1:    r = WAIT_W'(T_100US);
      default: r = WAIT_W'(T_40US);
    endcase
    return r;
  endfunction

  always_comb begin
    state_d       = state_q;
    nib_idx_d     = nib_idx_q;
    e_cnt_d       = e_cnt_q;
    cmd_idx_d     = cmd_idx_q;
    fetch_ph_d    = fetch_ph_q;
    next_instr_d  = 1'b0;
    db_d          = db_q;
    clk_cnt_d     = clk_cnt_q;
    char_addr_d   = char_addr_q;
    init_active_d = init_active_q;
    seq_done_d    = seq_done_q;
    tmr_load      = 1'b0;
    tmr_val       = '0;

    case (state_q)
      PWR_WAIT: begin
        if (tmr_expired) begin
          state_d   = INIT_NIB;
          nib_idx_d = 2'd0;
          e_cnt_d   = 4'd0;
        end
      end
      INIT_NIB: begin
        if (e_cnt_q == 4'(E_TOTAL_CYC - 1)) begin
          state_d  = INIT_WAIT;
          tmr_load = 1'b1;
          tmr_val  = init_wait_len(nib_idx_q);
        end else begin
          e_cnt_d = e_cnt_q + 4'd1;
        end
      end
      INIT_WAIT: begin
        if (tmr_expired) begin
          if (nib_idx_q != 2'd3) begin
            nib_idx_d = nib_idx_q + 2'd1;
            e_cnt_d   = 4'd0;
            state_d   = INIT_NIB;
          end else begin
            init_active_d = 1'b0;
            cmd_idx_d     = 3'd0;
            state_d       = CMD_ISSUE;
          end
        end
      end
      CMD_ISSUE: begin
        db_d         = cmd_db(cmd_idx_q);
        next_instr_d = 1'b1;
        clk_cnt_d    = 12'd0;
        state_d      = CMD_WAIT;
      end
      CMD_WAIT: begin
        clk_cnt_d = (clk_cnt_q == 12'hFFF) ? clk_cnt_q : clk_cnt_q + 12'd1;
        if (done) begin
          case (cmd_idx_q)
            CMD_IDX_CLEAR: begin
              state_d  = CLR_WAIT;
              tmr_load = 1'b1;
              tmr_val  = WAIT_W'(T_CLEAR);
            end
            CMD_IDX_L1: begin
              char_addr_d = 5'd0;
              fetch_ph_d  = 1'b0;
              state_d     = CHAR_FETCH;
            end
            CMD_IDX_L2: begin
              char_addr_d = START_L2;
              fetch_ph_d  = 1'b0;
              state_d     = CHAR_FETCH;
            end
            default: begin
              cmd_idx_d = cmd_idx_q + 3'd1;
              state_d   = CMD_ISSUE;
            end
          endcase
        end
      end
      CLR_WAIT: begin
        if (tmr_expired) begin
          cmd_idx_d = cmd_idx_q + 3'd1;
          state_d   = CMD_ISSUE;
        end
      end
      CHAR_FETCH: begin
        // First cycle presents the address; the ROM answers one cycle later.
        if (!fetch_ph_q) begin
          fetch_ph_d = 1'b1;
        end else begin
          fetch_ph_d = 1'b0;
          db_d       = {2'b10, char_data};
          state_d    = CHAR_ISSUE;
        end
      end
      CHAR_ISSUE: begin
        next_instr_d = 1'b1;
        clk_cnt_d    = 12'd0;
        state_d      = CHAR_WAIT;
      end
      CHAR_WAIT: begin
        clk_cnt_d = (clk_cnt_q == 12'hFFF) ? clk_cnt_q : clk_cnt_q + 12'd1;
        if (done) begin
          if (char_addr_q == LAST_L1) begin
            cmd_idx_d = CMD_IDX_L2;
            state_d   = CMD_ISSUE;
          end else if (char_addr_q == LAST_L2) begin
            seq_done_d = 1'b1;
            state_d    = DONE;
`ifdef LCD_SEQ_REFRESH_EN
            tmr_load   = 1'b1;
            tmr_val    = WAIT_W'(T_POWERON);
`endif
          end else begin
            char_addr_d = char_addr_q + 5'd1;
            fetch_ph_d  = 1'b0;
            state_d     = CHAR_FETCH;
          end
        end
      end
      DONE: begin
`ifdef LCD_SEQ_REFRESH_EN
        // Rewrite only the message; the panel keeps its configuration.
        if (tmr_expired) begin
          seq_done_d = 1'b0;
          cmd_idx_d  = CMD_IDX_L1;
          state_d    = CMD_ISSUE;
        end
`else
        state_d = DONE;
`endif
      end
      default: begin
        state_d = PWR_WAIT;
      end
    endcase

    init_sf_d_d  = (state_d == INIT_NIB) ? init_nibble(nib_idx_d) : init_sf_d_q;
    init_lcd_e_d = (state_d == INIT_NIB) &&
                   (e_cnt_d >= 4'(E_SETUP_CYC)) &&
                   (e_cnt_d < 4'(E_SETUP_CYC + E_HIGH_CYC));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= PWR_WAIT;
      nib_idx_q     <= 2'd0;
      e_cnt_q       <= 4'd0;
      cmd_idx_q     <= 3'd0;
      fetch_ph_q    <= 1'b0;
      next_instr_q  <= 1'b0;
      db_q          <= 10'd0;
      clk_cnt_q     <= 12'd0;
      char_addr_q   <= 5'd0;
      init_active_q <= 1'b1;
      init_sf_d_q   <= 4'd0;
      init_lcd_e_q  <= 1'b0;
      seq_done_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      nib_idx_q     <= nib_idx_d;
      e_cnt_q       <= e_cnt_d;
      cmd_idx_q     <= cmd_idx_d;
      fetch_ph_q    <= fetch_ph_d;
      next_instr_q  <= next_instr_d;
      db_q          <= db_d;
      clk_cnt_q     <= clk_cnt_d;
      char_addr_q   <= char_addr_d;
      init_active_q <= init_active_d;
      init_sf_d_q   <= init_sf_d_d;
      init_lcd_e_q  <= init_lcd_e_d;
      seq_done_q    <= seq_done_d;
    end
  end

  assign next_instruction = next_instr_q;
  assign db               = db_q;
  assign clk_cnt          = clk_cnt_q;
  assign char_addr        = char_addr_q;
  assign init_active      = init_active_q;
  assign init_sf_d        = init_sf_d_q;
  assign init_lcd_e       = init_lcd_e_q;
  assign seq_done         = seq_done_q;

endmodule
`default_nettype wire

// File: tb/tb_lcd_command_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_lcd_command_sequencer : scoreboard bench with an instruction-FSM      |
// |   model and a registered message ROM (char_data = 0x41 + addr).          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_lcd_command_sequencer;

  localparam int TP  = 100;
  localparam int T41 = 60;
  localparam int T1  = 30;
  localparam int T40 = 10;
  localparam int TC  = 50;
  localparam int NC  = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        done = 1'b0;
  logic [7:0]  char_data = 8'h00;
  logic        next_instruction;
  logic [9:0]  db;
  logic [11:0] clk_cnt;
  logic [4:0]  char_addr;
  logic        init_active;
  logic [3:0]  init_sf_d;
  logic        init_lcd_e;
  logic        seq_done;

  lcd_command_sequencer #(
    .T_POWERON (TP), .T_4100US (T41), .T_100US (T1), .T_40US (T40),
    .T_CLEAR (TC), .NUM_COLS (NC), .WAIT_W (20)
  ) dut (
    .clk (clk), .reset (reset), .done (done), .char_data (char_data),
    .next_instruction (next_instruction), .db (db), .clk_cnt (clk_cnt),
    .char_addr (char_addr), .init_active (init_active), .init_sf_d (init_sf_d),
    .init_lcd_e (init_lcd_e), .seq_done (seq_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Message buffer ROM with one cycle of read latency
  always @(posedge clk) char_data <= 8'h41 + {3'b000, char_addr};

  int n_vec = 0;
  int n_err = 0;
  int spur_req = 0;
  int n_epulse = 0;

  logic [9:0] exp_db[$];
  logic [3:0] exp_nib[$];
  int         exp_gap[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_msg();
    exp_db.push_back(10'h080);
    for (int i = 0; i < NC; i++) exp_db.push_back(10'h241 + 10'(i));
    exp_db.push_back(10'h0C0);
    for (int i = NC; i < 2 * NC; i++) exp_db.push_back(10'h241 + 10'(i));
  endtask

  task automatic push_all();
    exp_nib.push_back(4'h3); exp_nib.push_back(4'h3);
    exp_nib.push_back(4'h3); exp_nib.push_back(4'h2);
    exp_gap.push_back(T41); exp_gap.push_back(T1);
    exp_gap.push_back(T40); exp_gap.push_back(T40);
    exp_db.push_back(10'h028); exp_db.push_back(10'h006);
    exp_db.push_back(10'h00C); exp_db.push_back(10'h001);
    push_msg();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_init_active"}, init_active, 1);
    check({tag, "_next_instruction"}, next_instruction, 0);
    check({tag, "_db"}, db, 0);
    check({tag, "_clk_cnt"}, clk_cnt, 0);
    check({tag, "_char_addr"}, char_addr, 0);
    check({tag, "_init_sf_d"}, init_sf_d, 0);
    check({tag, "_init_lcd_e"}, init_lcd_e, 0);
    check({tag, "_seq_done"}, seq_done, 0);
  endtask

  task automatic wait_seq_done(input int budget, input string name);
    int n = 0;
    while (!seq_done && n < budget) begin @(negedge clk); n++; end
    check(name, seq_done, 1);
  endtask

  // Scoreboard monitor: every instruction pulse pops one expected db
  initial begin
    forever begin
      @(negedge clk);
      if (reset && next_instruction) begin
        if (exp_db.size() == 0) check("instr_unexpected", 1, 0);
        else check("db_issue", db, exp_db.pop_front());
        check("clk_cnt_at_issue", clk_cnt, 0);
        check("seq_done_while_busy", seq_done, 0);
        check("init_active_during_cmd", init_active, 0);
      end
    end
  end

  // Instruction FSM model: done after a per-instruction delay
  initial begin
    int ncyc, delay, clr_cyc, spur_ack;
    logic busy;
    logic [9:0] cur_db;
    busy = 1'b0; clr_cyc = -1; spur_ack = 0; ncyc = 0; delay = 5; cur_db = '0;
    forever begin
      @(negedge clk);
      done = 1'b0;
      if (!reset) begin
        busy = 1'b0; clr_cyc = -1; spur_ack = spur_req;
      end else if (next_instruction) begin
        check("one_outstanding", busy, 0);
        if (clr_cyc >= 0) begin
          check("clear_gap", ((cyc - clr_cyc) > TC) && ((cyc - clr_cyc) <= TC + 3), 1);
          clr_cyc = -1;
        end
        busy = 1'b1; cur_db = db; ncyc = 0;
        delay = (db == 10'h028) ? 2181 : (db == 10'h00C) ? 4100 : 5;
      end else if (busy) begin
        ncyc++;
        if (ncyc == delay) begin
          check("clk_cnt_at_done", clk_cnt, (delay > 4095) ? 4095 : delay);
          check("db_held", db, cur_db);
          done = 1'b1; busy = 1'b0;
          if (cur_db == 10'h001) clr_cyc = cyc;
        end
      end else if (spur_req != spur_ack) begin
        done = 1'b1; spur_ack = spur_req;
      end
    end
  end

  // Init nibble monitor: values, E width, fall-to-fall spacing
  initial begin
    logic e_prev, ia_prev;
    int rel, rise_cyc, fall_cyc, nib_seen, want_gap;
    e_prev = 1'b0; ia_prev = 1'b1; rel = 0; rise_cyc = 0; fall_cyc = 0;
    nib_seen = 0; want_gap = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        e_prev = 1'b0; ia_prev = 1'b1; nib_seen = 0; rel = cyc;
      end else begin
        if (init_lcd_e && !e_prev) begin
          // The first edge with reset high counts as cycle 0
          if (nib_seen == 0) check("first_e_rise", cyc - rel - 1, TP + 2);
          if (exp_nib.size() == 0) check("nib_unexpected", 1, 0);
          else check("init_sf_d", init_sf_d, exp_nib.pop_front());
          check("init_active_nib", init_active, 1);
          rise_cyc = cyc;
        end
        if (!init_lcd_e && e_prev) begin
          check("e_width", cyc - rise_cyc, 12);
          // hold 1 + wait W+1 + setup 2 + pulse 12
          if (nib_seen > 0) check("e_fall_spacing", cyc - fall_cyc, want_gap + 16);
          if (exp_gap.size() > 0) want_gap = exp_gap.pop_front();
          fall_cyc = cyc;
          nib_seen++;
          n_epulse++;
        end
        if (!init_active && ia_prev) begin
          check("init_active_fall", cyc - fall_cyc, want_gap + 2);
          check("nibbles_seen", nib_seen, 4);
        end
        e_prev = init_lcd_e;
        ia_prev = init_active;
      end
    end
  end

  initial begin
    int n;
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    #1 check_reset_values("rst");
    push_all();
    @(negedge clk);
    #2 reset = 1'b1;

    // Pass 0: run into line 1 and reset in the middle of character 7
    n = 0;
    while (!(char_addr == 5'd7 && !init_active) && n < 30000) begin @(negedge clk); n++; end
    check("reach_char7", char_addr, 7);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1 check_reset_values("midrst");
    repeat (3) @(negedge clk);
    exp_db.delete(); exp_nib.delete(); exp_gap.delete();
    push_all();
    @(negedge clk);
    #2 reset = 1'b1;

    // Pass 1: full sequence, with a stray done during the power-on wait
    repeat (20) @(negedge clk);
    spur_req++;
    wait_seq_done(30000, "pass1_seq_done");
    @(negedge clk);
    check("pass1_queue_empty", exp_db.size(), 0);
    check("pass1_nibs_empty", exp_nib.size(), 0);
    check("pass1_char_addr", char_addr, 2 * NC - 1);
    check("pass1_no_pulse_in_done", next_instruction, 0);
    check("pass1_init_active", init_active, 0);

`ifdef LCD_SEQ_REFRESH_EN
    begin
      int ep;
      ep = n_epulse;
      push_msg();
      n = 0;
      while (seq_done && n < TP + 20) begin @(negedge clk); n++; end
      check("refresh_seq_done_cleared", seq_done, 0);
      check("refresh_delay", (n >= TP) && (n <= TP + 3), 1);
      wait_seq_done(3000, "refresh_seq_done");
      @(negedge clk);
      check("refresh_queue_empty", exp_db.size(), 0);
      check("refresh_no_init", n_epulse, ep);
    end
`else
    repeat (TP + 50) @(negedge clk);
    check("done_terminal_seq_done", seq_done, 1);
    check("done_terminal_queue", exp_db.size(), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
